// File: rtl/t03_sprite_fetch_arbiter_if.sv
// ---------------------------------------------------------------------------
// t03_sprite_fetch_arbiter_if
// Bus between the sprite line loaders, the fetch arbiter and sprite memory.
//   req/gnt           : per-requester request and one-hot grant (0=P1, 1=P2, 2=text)
//   addr_p1/p2/txt    : per-requester read address, held stable with req
//   mem_rd_en/addr    : read strobe and address toward sprite memory
//   mem_rdata         : sprite memory read data
//   rd_valid/rd_data  : one-hot return strobe and return data toward requesters
// Modports: slave = the arbiter, master = the requesters plus memory.
// ---------------------------------------------------------------------------
interface t03_sprite_fetch_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic [2:0]        req;
    logic [2:0]        gnt;
    logic [ADDR_W-1:0] addr_p1;
    logic [ADDR_W-1:0] addr_p2;
    logic [ADDR_W-1:0] addr_txt;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [2:0]        rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport slave (
        input  req, addr_p1, addr_p2, addr_txt, mem_rdata,
        output gnt, mem_rd_en, mem_addr, rd_valid, rd_data
    );

    modport master (
        output req, addr_p1, addr_p2, addr_txt, mem_rdata,
        input  gnt, mem_rd_en, mem_addr, rd_valid, rd_data
    );
endinterface

// File: rtl/t03_sprite_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// t03_sprite_fetch_arbiter
// Shares one sprite-memory read port between player 1 (req 0), player 2
// (req 1) and text (req 2) sprite loaders. Grants are only issued while
// fetch_win is high; each read is tagged and its data routed back to the
// requester that issued it, in issue order.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   fetch_win  : 1 = blanking fetch window open, new grants allowed
//   bus        : t03_sprite_fetch_arbiter_if.slave (req/gnt, addresses,
//                memory read port, tagged return)
//   busy       : 1 while the controller is not IDLE
// Build option: define T03_ARB_FIXED_PRIO_EN for fixed priority
// req0 > req1 > req2 (round-robin pointer removed); default is round-robin.
// ---------------------------------------------------------------------------
module t03_sprite_fetch_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_win,
    t03_sprite_fetch_arbiter_if.slave   bus,
    output logic                        busy
);
    // One stage per cycle from issue until mem_rdata is valid.
    localparam int DEPTH = READ_LAT + 1;

    typedef enum logic [1:0] {IDLE, ARB, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [DEPTH-1:0]  tag_vld;
    logic [1:0]        tag_id [DEPTH];
    logic              pipe_busy;
    logic [2:0]        pick;
    logic [2:0]        gnt;
    logic              hs;
    logic [1:0]        win_id;
    logic [ADDR_W-1:0] win_addr;
`ifndef T03_ARB_FIXED_PRIO_EN
    logic [1:0]        last;
`endif

    assign pipe_busy = |tag_vld;
    assign busy      = (state != IDLE);

    // Requester selection
`ifdef T03_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        if (bus.req[0])      pick = 3'b001;
        else if (bus.req[1]) pick = 3'b010;
        else if (bus.req[2]) pick = 3'b100;
    end
`else
    // Search starts one past the last granted requester.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            idx = 2'((32'(last) + 32'd1 + k) % 32'd3);
            if (!found && bus.req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        gnt      = (state == ARB && fetch_win) ? pick : '0;
        hs       = |gnt;
        win_id   = 2'd0;
        win_addr = bus.addr_p1;
        case (gnt)
            3'b010: begin win_id = 2'd1; win_addr = bus.addr_p2;  end
            3'b100: begin win_id = 2'd2; win_addr = bus.addr_txt; end
            default: ;
        endcase
    end

    assign bus.gnt = gnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_win) state_nxt = ARB;
            ARB:     if (!fetch_win) state_nxt = pipe_busy ? DRAIN : IDLE;
            DRAIN:   if (!pipe_busy) state_nxt = fetch_win ? ARB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifndef T03_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     last <= 2'd2;
        else if (hs) last <= win_id;
    end
`endif

    // Read issue, tag pipeline and return routing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            tag_vld       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) tag_id[i] <= '0;
            bus.rd_valid  <= '0;
            bus.rd_data   <= '0;
        end else begin
            bus.mem_rd_en <= hs;
            if (hs) bus.mem_addr <= win_addr;
            tag_vld   <= {tag_vld[DEPTH-2:0], hs};
            tag_id[0] <= win_id;
            for (int unsigned i = 1; i < DEPTH; i++) tag_id[i] <= tag_id[i-1];
            // Last stage lines up with mem_rdata being valid.
            if (tag_vld[DEPTH-1]) begin
                bus.rd_valid <= 3'(3'b001 << tag_id[DEPTH-1]);
                bus.rd_data  <= bus.mem_rdata;
            end else begin
                bus.rd_valid <= '0;
            end
        end
    end
endmodule
